// File: rtl/mips_mem_pkg.sv
// Shared definitions for the fetch/data memory arbiter.
//   arb_state_e     : arbiter FSM state encoding (IDLE, BUSY_I, BUSY_D)
//   TIMEOUT_DEFAULT : default ack-wait limit used by the arbiter and its watchdog
//   WORD_W          : address/data word width
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WORD_W          = 32;

endpackage

// File: rtl/ack_watchdog.sv
// Ack watchdog: counts consecutive cycles spent waiting for a memory ack.
//   clk, rst : clock, synchronous active-high reset
//   busy     : a memory transaction is outstanding this cycle
//   ack      : memory completion this cycle
//   expired  : high in the cycle that is the TIMEOUT-th consecutive busy
//              cycle without an ack (combinational from the count register)
// The count clears whenever the arbiter is idle or an ack arrives, and
// saturates at TIMEOUT so a very long wait cannot wrap and re-fire.
module ack_watchdog
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic ack,
    output logic expired
);

    // A limit below one cycle is meaningless; clamp so the widths stay legal.
    localparam int LIMIT = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             waiting;

    assign waiting = busy & ~ack;
    // count_q holds the number of unacked busy cycles already completed, so
    // this cycle is the LIMIT-th one when count_q == LIMIT-1.
    assign expired = waiting & (count_q == CNT_LAST);

    always_comb begin
        count_d = '0;
        if (waiting) begin
            count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a shared single-port memory.
//   clk, rst                     : clock, synchronous active-high reset
//   if_req/if_addr               : fetch read request (held until if_ready)
//   if_rdata/if_ready            : registered fetch data, one-cycle done pulse
//   dm_read/dm_write/dm_addr/
//   dm_wdata                     : load/store request (held until dm_ready)
//   dm_rdata/dm_ready            : registered load data, one-cycle done pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                    : registered request to the shared memory
//   mem_rdata/mem_ack            : memory response, only honoured while busy
//   stall                        : combinational pipeline stall
//   timeout_err                  : sticky "ack took too long" flag
// Data requests win over fetches because the MEM stage holds the older
// instruction. A port whose ready is high this cycle is not granted, so a
// requester that is still holding its request in the ready cycle is not
// served twice.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic [WORD_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              timeout_err
);

    arb_state_e        state_q,       state_d;
    logic              mem_req_q,     mem_req_d;
    logic              mem_we_q,      mem_we_d;
    logic [WORD_W-1:0] mem_addr_q,    mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic [WORD_W-1:0] if_rdata_q,    if_rdata_d;
    logic [WORD_W-1:0] dm_rdata_q,    dm_rdata_d;
    logic              if_ready_q,    if_ready_d;
    logic              dm_ready_q,    dm_ready_d;
    logic              timeout_err_q, timeout_err_d;

    logic busy;
    logic wd_expired;
    logic dm_active;
    logic dm_eligible;
    logic if_eligible;

    assign busy        = (state_q != IDLE);
    assign dm_active   = dm_read | dm_write;
    assign dm_eligible = dm_active & ~dm_ready_q;
    assign if_eligible = if_req & ~if_ready_q;

    ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_ack_watchdog (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .ack     (mem_ack),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        dm_rdata_d    = dm_rdata_q;
        if_ready_d    = 1'b0;
        dm_ready_d    = 1'b0;
        timeout_err_d = timeout_err_q | wd_expired;

        case (state_q)
            IDLE: begin
                // mem_ack is ignored here: nothing is outstanding.
                if (dm_eligible) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    // read+write together is a store.
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_eligible) begin
                    state_d    = BUSY_I;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            BUSY_I: begin
                // Completion is independent of if_req so a flushed fetch
                // still finishes cleanly.
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_ready_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            if_ready_q    <= 1'b0;
            dm_ready_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            dm_rdata_q    <= dm_rdata_d;
            if_ready_q    <= if_ready_d;
            dm_ready_q    <= dm_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign stall       = (if_req & ~if_ready_q) | (dm_active & ~dm_ready_q);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_ready    = if_ready_q;
    assign dm_ready    = dm_ready_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized fetch/data traffic against a transaction-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_arbiter;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference memory contents for the random test.
    logic [31:0] mem_model [int unsigned];

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .timeout_err(timeout_err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
        dm_addr = 0; dm_wdata = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    function automatic logic [31:0] mem_value(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step(); step();
        checks++; if (mem_req !== 1'b0)      begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0)       begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0)    begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0)   begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (if_rdata !== 32'h0)    begin errors++; $display("FAIL reset_if_rdata: got %h want 0", if_rdata); end
        checks++; if (dm_rdata !== 32'h0)    begin errors++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); end
        checks++; if (if_ready !== 1'b0)     begin errors++; $display("FAIL reset_if_ready: got %b want 0", if_ready); end
        checks++; if (dm_ready !== 1'b0)     begin errors++; $display("FAIL reset_dm_ready: got %b want 0", dm_ready); end
        checks++; if (timeout_err !== 1'b0)  begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        checks++; if (stall !== 1'b0)        begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 0;
    endtask

    // Single fetch, ack one cycle after mem_req rises.
    task automatic test_fetch();
        if_req = 1; if_addr = 32'h40;
        step();
        checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL fetch_mem_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h40)     begin errors++; $display("FAIL fetch_mem_addr: got %h want 00000040", mem_addr); end
        checks++; if (mem_we !== 1'b0)         begin errors++; $display("FAIL fetch_mem_we: got %b want 0", mem_we); end
        checks++; if (stall !== 1'b1)          begin errors++; $display("FAIL fetch_stall_busy: got %b want 1", stall); end
        step();
        checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL fetch_mem_req_hold: got %b want 1", mem_req); end
        mem_ack = 1; mem_rdata = 32'h8C01_0004;
        step();
        mem_ack = 0; mem_rdata = 32'h0;
        checks++; if (if_ready !== 1'b1)       begin errors++; $display("FAIL fetch_if_ready: got %b want 1", if_ready); end
        checks++; if (if_rdata !== 32'h8C010004) begin errors++; $display("FAIL fetch_if_rdata: got %h want 8c010004", if_rdata); end
        checks++; if (mem_req !== 1'b0)        begin errors++; $display("FAIL fetch_mem_req_drop: got %b want 0", mem_req); end
        checks++; if (stall !== 1'b0)          begin errors++; $display("FAIL fetch_stall_done: got %b want 0", stall); end
        $display("txn fetch addr=%h rdata=%h", 32'h40, if_rdata);
        if_req = 0;
        step();
        checks++; if (if_ready !== 1'b0)       begin errors++; $display("FAIL fetch_ready_once: got %b want 0", if_ready); end
        checks++; if (mem_req !== 1'b0)        begin errors++; $display("FAIL fetch_no_regrant: got %b want 0", mem_req); end
    endtask

    // Fetch and load arrive together: load first, fetch right after.
    task automatic test_priority();
        if_req = 1; if_addr = 32'h200; dm_read = 1; dm_addr = 32'h100;
        step();
        checks++; if (mem_addr !== 32'h100)    begin errors++; $display("FAIL prio_first_addr: got %h want 00000100", mem_addr); end
        checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL prio_first_req: got %b want 1", mem_req); end
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        step();
        checks++; if (dm_ready !== 1'b1)       begin errors++; $display("FAIL prio_dm_ready: got %b want 1", dm_ready); end
        checks++; if (dm_rdata !== 32'h11111111) begin errors++; $display("FAIL prio_dm_rdata: got %h want 11111111", dm_rdata); end
        checks++; if (stall !== 1'b1)          begin errors++; $display("FAIL prio_stall_fetch_wait: got %b want 1", stall); end
        $display("txn load addr=%h rdata=%h", 32'h100, dm_rdata);
        mem_ack = 0; dm_read = 0;
        step();
        checks++; if (dm_ready !== 1'b0)       begin errors++; $display("FAIL prio_dm_ready_low: got %b want 0", dm_ready); end
        checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL prio_fetch_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 32'h200)    begin errors++; $display("FAIL prio_fetch_addr: got %h want 00000200", mem_addr); end
        mem_ack = 1; mem_rdata = 32'h2222_2222;
        step();
        checks++; if (if_ready !== 1'b1)       begin errors++; $display("FAIL prio_if_ready: got %b want 1", if_ready); end
        checks++; if (if_rdata !== 32'h22222222) begin errors++; $display("FAIL prio_if_rdata: got %h want 22222222", if_rdata); end
        $display("txn fetch addr=%h rdata=%h", 32'h200, if_rdata);
        mem_ack = 0; if_req = 0;
        step();
    endtask

    // Store: memory sees address and data, dm_rdata is untouched.
    task automatic test_store();
        dm_write = 1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
        step();
        checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL store_req: got %b want 1", mem_req); end
        checks++; if (mem_we !== 1'b1)         begin errors++; $display("FAIL store_we: got %b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h20)     begin errors++; $display("FAIL store_addr: got %h want 00000020", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata: got %h want deadbeef", mem_wdata); end
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        step();
        checks++; if (dm_ready !== 1'b1)       begin errors++; $display("FAIL store_ready: got %b want 1", dm_ready); end
        checks++; if (dm_rdata !== 32'h11111111) begin errors++; $display("FAIL store_rdata_kept: got %h want 11111111", dm_rdata); end
        $display("txn store addr=%h wdata=%h", 32'h20, 32'hDEADBEEF);
        mem_ack = 0; dm_write = 0;
        step();
        checks++; if (dm_ready !== 1'b0)       begin errors++; $display("FAIL store_ready_once: got %b want 0", dm_ready); end
    endtask

    // Ack withheld for 300 busy cycles; error sets after the 255th.
    task automatic test_timeout();
        if_req = 1; if_addr = 32'h300;
        step();
        for (int k = 1; k <= 300; k++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_req_cycle%0d: got %b want 1", k, mem_req); end
            checks++; if (timeout_err !== (k > TO)) begin errors++; $display("FAIL timeout_err_cycle%0d: got %b want %b", k, timeout_err, (k > TO)); end
            if (k == 300) begin mem_ack = 1; mem_rdata = 32'h3333_3333; end
            step();
        end
        mem_ack = 0;
        checks++; if (if_ready !== 1'b1)       begin errors++; $display("FAIL timeout_if_ready: got %b want 1", if_ready); end
        checks++; if (if_rdata !== 32'h33333333) begin errors++; $display("FAIL timeout_if_rdata: got %h want 33333333", if_rdata); end
        checks++; if (timeout_err !== 1'b1)    begin errors++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
        $display("txn fetch addr=%h rdata=%h (late ack)", 32'h300, if_rdata);
        if_req = 0;
        step();
        checks++; if (timeout_err !== 1'b1)    begin errors++; $display("FAIL timeout_sticky_idle: got %b want 1", timeout_err); end
    endtask

    // Reset while a load is outstanding abandons it.
    task automatic test_reset_mid();
        dm_read = 1; dm_addr = 32'h44;
        step();
        checks++; if (mem_req !== 1'b1)        begin errors++; $display("FAIL rstmid_busy: got %b want 1", mem_req); end
        rst = 1;
        step();
        checks++; if (mem_req !== 1'b0)        begin errors++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0)      begin errors++; $display("FAIL rstmid_mem_addr: got %h want 0", mem_addr); end
        checks++; if (if_rdata !== 32'h0)      begin errors++; $display("FAIL rstmid_if_rdata: got %h want 0", if_rdata); end
        checks++; if (dm_rdata !== 32'h0)      begin errors++; $display("FAIL rstmid_dm_rdata: got %h want 0", dm_rdata); end
        checks++; if (dm_ready !== 1'b0)       begin errors++; $display("FAIL rstmid_dm_ready: got %b want 0", dm_ready); end
        checks++; if (timeout_err !== 1'b0)    begin errors++; $display("FAIL rstmid_timeout_err: got %b want 0", timeout_err); end
        rst = 0; dm_read = 0; mem_ack = 1; mem_rdata = 32'h4444_4444;
        step();
        mem_ack = 0;
        checks++; if (dm_ready !== 1'b0)       begin errors++; $display("FAIL rstmid_late_ack_ready: got %b want 0", dm_ready); end
        checks++; if (dm_rdata !== 32'h0)      begin errors++; $display("FAIL rstmid_late_ack_rdata: got %h want 0", dm_rdata); end
        checks++; if (mem_req !== 1'b0)        begin errors++; $display("FAIL rstmid_late_ack_req: got %b want 0", mem_req); end
        $display("txn load addr=%h abandoned by reset", 32'h44);
        step();
    endtask

    // Zero-wait ack with if_req held through the ready cycle: one grant only.
    task automatic test_back_to_back();
        int grants;
        grants = 0;
        if_req = 1; if_addr = 32'h84;
        step();
        if (mem_req === 1'b1) grants++;
        mem_ack = 1; mem_rdata = 32'h8484_8484;
        step();
        mem_ack = 0;
        checks++; if (if_ready !== 1'b1)       begin errors++; $display("FAIL b2b_if_ready: got %b want 1", if_ready); end
        checks++; if (if_rdata !== 32'h84848484) begin errors++; $display("FAIL b2b_if_rdata: got %h want 84848484", if_rdata); end
        $display("txn fetch addr=%h rdata=%h (zero wait)", 32'h84, if_rdata);
        step();
        if (mem_req === 1'b1) grants++;
        checks++; if (if_ready !== 1'b0)       begin errors++; $display("FAIL b2b_ready_once: got %b want 0", if_ready); end
        if_req = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (mem_req === 1'b1) grants++;
        end
        checks++; if (grants !== 1)            begin errors++; $display("FAIL b2b_grant_count: got %0d want 1", grants); end
    endtask

    // Random traffic from two requesters and a random-latency memory.
    task automatic test_random();
        int          if_st, dm_st, lat, kind;
        int          if_issued, if_done, dm_issued, dm_done;
        logic        busy_m, owner_d, t_we, drain, ack_v;
        logic [31:0] t_addr, t_wdata, rdata_v;
        logic        exp_mem_req, exp_if_ready, exp_dm_ready, exp_stall, n_if_ready, n_dm_ready;
        logic [31:0] exp_if_rdata, exp_dm_rdata;

        idle_inputs();
        rst = 1;
        step();
        rst = 0;
        if_st = 0; dm_st = 0; lat = 0; busy_m = 0; owner_d = 0; t_we = 0;
        t_addr = 0; t_wdata = 0;
        if_issued = 0; if_done = 0; dm_issued = 0; dm_done = 0;
        exp_mem_req = 0; exp_if_ready = 0; exp_dm_ready = 0;
        exp_if_rdata = 0; exp_dm_rdata = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            drain = (cyc >= 2950);
            exp_stall = (if_req & ~exp_if_ready) | ((dm_read | dm_write) & ~exp_dm_ready);
            checks++; if (mem_req !== exp_mem_req) begin errors++; $display("FAIL rnd_mem_req cyc%0d: got %b want %b", cyc, mem_req, exp_mem_req); end
            if (exp_mem_req) begin
                checks++; if (mem_addr !== t_addr) begin errors++; $display("FAIL rnd_mem_addr cyc%0d: got %h want %h", cyc, mem_addr, t_addr); end
                checks++; if (mem_we !== t_we)     begin errors++; $display("FAIL rnd_mem_we cyc%0d: got %b want %b", cyc, mem_we, t_we); end
                if (t_we) begin
                    checks++; if (mem_wdata !== t_wdata) begin errors++; $display("FAIL rnd_mem_wdata cyc%0d: got %h want %h", cyc, mem_wdata, t_wdata); end
                end
            end
            checks++; if (if_ready !== exp_if_ready) begin errors++; $display("FAIL rnd_if_ready cyc%0d: got %b want %b", cyc, if_ready, exp_if_ready); end
            checks++; if (dm_ready !== exp_dm_ready) begin errors++; $display("FAIL rnd_dm_ready cyc%0d: got %b want %b", cyc, dm_ready, exp_dm_ready); end
            checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL rnd_if_rdata cyc%0d: got %h want %h", cyc, if_rdata, exp_if_rdata); end
            checks++; if (dm_rdata !== exp_dm_rdata) begin errors++; $display("FAIL rnd_dm_rdata cyc%0d: got %h want %h", cyc, dm_rdata, exp_dm_rdata); end
            checks++; if (stall !== exp_stall)       begin errors++; $display("FAIL rnd_stall cyc%0d: got %b want %b", cyc, stall, exp_stall); end
            checks++; if (timeout_err !== 1'b0)      begin errors++; $display("FAIL rnd_timeout_err cyc%0d: got %b want 0", cyc, timeout_err); end

            // Fetch requester: 0 idle, 1 requesting, 2 flushed, 3 holding one cycle past ready.
            if (exp_if_ready) begin
                if_done++;
                if (if_st == 1 && $urandom_range(0, 1) == 1) if_st = 3;
                else begin if_req = 0; if_st = 0; end
            end else if (if_st == 3) begin
                if_req = 0; if_st = 0;
            end else if (if_st == 0) begin
                if (!drain && $urandom_range(0, 9) < 3) begin
                    if_req = 1; if_addr = 32'($urandom_range(0, 15)) << 2; if_st = 1; if_issued++;
                end
            end else if (if_st == 1 && busy_m && !owner_d && $urandom_range(0, 19) == 0) begin
                if_req = 0; if_st = 2;
            end

            // Data requester, same states; kind 3 drives read and write together.
            if (exp_dm_ready) begin
                dm_done++;
                if (dm_st == 1 && $urandom_range(0, 1) == 1) dm_st = 3;
                else begin dm_read = 0; dm_write = 0; dm_st = 0; end
            end else if (dm_st == 3) begin
                dm_read = 0; dm_write = 0; dm_st = 0;
            end else if (dm_st == 0) begin
                if (!drain && $urandom_range(0, 9) < 3) begin
                    kind = $urandom_range(0, 3);
                    dm_read = (kind != 2); dm_write = (kind >= 2);
                    dm_addr = 32'($urandom_range(0, 15)) << 2; dm_wdata = $urandom;
                    dm_st = 1; dm_issued++;
                end
            end else if (dm_st == 1 && busy_m && owner_d && $urandom_range(0, 19) == 0) begin
                dm_read = 0; dm_write = 0; dm_st = 2;
            end

            // Memory: random latency while busy, occasional stray ack while idle.
            ack_v = 0; rdata_v = $urandom;
            if (busy_m) begin
                if (lat == 0) ack_v = 1; else lat--;
                if (ack_v && !t_we) rdata_v = mem_value(t_addr);
            end else begin
                ack_v = ($urandom_range(0, 7) == 0);
            end
            mem_ack = ack_v; mem_rdata = rdata_v;

            // Reference: what the arbiter must do at the coming edge.
            n_if_ready = 0; n_dm_ready = 0;
            if (busy_m) begin
                if (ack_v) begin
                    busy_m = 0;
                    if (owner_d) begin
                        n_dm_ready = 1;
                        if (t_we) mem_model[t_addr] = t_wdata;
                        else exp_dm_rdata = rdata_v;
                        $display("txn %s addr=%h data=%h", t_we ? "store" : "load", t_addr, t_we ? t_wdata : rdata_v);
                    end else begin
                        n_if_ready = 1;
                        exp_if_rdata = rdata_v;
                        $display("txn fetch addr=%h data=%h", t_addr, rdata_v);
                    end
                end
            end else if ((dm_read | dm_write) && !exp_dm_ready) begin
                busy_m = 1; owner_d = 1; t_addr = dm_addr; t_we = dm_write; t_wdata = dm_wdata;
                lat = $urandom_range(0, 4);
            end else if (if_req && !exp_if_ready) begin
                busy_m = 1; owner_d = 0; t_addr = if_addr; t_we = 0;
                lat = $urandom_range(0, 4);
            end
            exp_mem_req = busy_m; exp_if_ready = n_if_ready; exp_dm_ready = n_dm_ready;
            step();
        end
        mem_ack = 0;
        checks++; if (if_done !== if_issued) begin errors++; $display("FAIL rnd_fetch_completions: got %0d want %0d", if_done, if_issued); end
        checks++; if (dm_done !== dm_issued) begin errors++; $display("FAIL rnd_data_completions: got %0d want %0d", dm_done, dm_issued); end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not complete within bound");
        $fatal(1, "time limit");
    end

endmodule
